bram_read_server: RTL and testbench

- Request/response front end that sits directly upstream of the dual-port BRAM and drives one of its ports.
- Converts a valid/ready request stream (reads and writes) into BRAM enable/write strobes.
- Tracks the BRAM's fixed read latency, which depends on PIPELINED, and captures read data into a response FIFO.
- Credit accounting guarantees read data is never dropped under response backpressure.

---
 rtl/bram_read_server.sv | 127 ++++++++++++
 tb/tb_bram_read_server.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_read_server.sv
// bram_read_server: valid/ready front end for one port of a dual-port BRAM.
// Requests become BRAM enable/write strobes in the same cycle. Reads are
// tracked through the BRAM's fixed latency and their data is captured in a
// small response FIFO. Read credits reserve a FIFO slot at accept time, so
// data coming back from the BRAM always has somewhere to land.
module bram_read_server #(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1,
  parameter int PIPELINED  = 1,
  parameter int RESP_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WRITE,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ_DATA,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [DATA_WIDTH-1:0] RSP_DATA,
  output logic                  BRAM_EN,
  output logic                  BRAM_WE,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
  output logic [DATA_WIDTH-1:0] BRAM_DI,
  input  logic [DATA_WIDTH-1:0] BRAM_DO
);

  // BRAM read latency: the output register adds one stage when pipelined.
  localparam int LAT = (PIPELINED != 0) ? 2 : 1;
  // Pointer width (RESP_DEPTH >= 2, so at least 1 bit) and counter width
  // wide enough to hold the value RESP_DEPTH itself.
  localparam int PW = $clog2(RESP_DEPTH);
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(RESP_DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(RESP_DEPTH - 1);

  logic [CW-1:0]         credits_q, credits_d;
  logic [CW-1:0]         occ_q, occ_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LAT-1:0]        vld_pipe_q, vld_pipe_d;
  logic [DATA_WIDTH-1:0] fifo_q [2**PW];

  logic acc;     // request handshake this cycle
  logic rd_acc;  // accepted request is a read
  logic push;    // BRAM_DO holds read data this cycle
  logic pop;     // consumer takes the FIFO head

  // Pointers wrap at RESP_DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Writes also wait for a credit even though they never consume one, so
  // REQ_READY stays independent of the request type.
  assign REQ_READY = ~RST & (credits_q != '0);
  assign acc       = REQ_VALID & REQ_READY;
  assign rd_acc    = acc & ~REQ_WRITE;

  // The BRAM port is driven straight from the accepted request.
  assign BRAM_EN   = acc;
  assign BRAM_WE   = acc & REQ_WRITE;
  assign BRAM_ADDR = REQ_ADDR;
  assign BRAM_DI   = REQ_DATA;

  // The oldest in-flight read reaches the end of the pipe exactly when its
  // data is on BRAM_DO.
  assign push = vld_pipe_q[LAT-1];

  // Response side: head of FIFO, masked during reset.
  assign RSP_VALID = ~RST & (occ_q != '0);
  assign pop       = RSP_VALID & RSP_READY;
  assign RSP_DATA  = fifo_q[rd_ptr_q];

  // Next-state for credits, occupancy and FIFO pointers.
  always_comb begin
    credits_d = credits_q;
    occ_d     = occ_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    // A read takes a credit; a pop returns one; both together cancel.
    case ({rd_acc, pop})
      2'b10:   credits_d = credits_q - 1'b1;
      2'b01:   credits_d = credits_q + 1'b1;
      default: credits_d = credits_q;
    endcase
    // Push and pop together leave occupancy unchanged, even when full.
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
  end

  // In-flight valid shift register, one stage per cycle of BRAM latency.
  always_comb begin
    vld_pipe_d    = '0;
    vld_pipe_d[0] = rd_acc;
    for (int i = 1; i < LAT; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
  end

  // Control state; reset drops in-flight reads and FIFO contents silently.
  always_ff @(posedge CLK) begin
    if (RST) begin
      credits_q  <= CRED_MAX;
      occ_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      vld_pipe_q <= '0;
    end else begin
      credits_q  <= credits_d;
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  // Response storage: captures BRAM_DO at the tail when a read lands.
  always_ff @(posedge CLK) begin
    if (push) fifo_q[wr_ptr_q] <= BRAM_DO;
  end

endmodule

// File: tb/tb_bram_read_server.sv
// Bench for bram_read_server: two instances (pipelined and non-pipelined
// BRAM, 4 response entries) each attached to a behavioural BRAM. A
// transaction-level model predicts every output every cycle; directed
// sequences add literal expectations.
module tb_bram_read_server;

  localparam int DEPTH = 4;

  typedef struct {
    int         k;    // instance
    logic [7:0] d;    // expected read data
    int         rdy;  // first cycle the response may be visible
  } ent_t;

  logic       clk, rst;
  logic       req_valid [2], req_ready [2], req_write [2];
  logic       rsp_valid [2], rsp_ready [2], bram_en [2], bram_we [2];
  logic [3:0] req_addr [2], bram_addr [2];
  logic [7:0] req_data [2], rsp_data [2], bram_di [2];

  int         errors, checks, cyc;
  ent_t       pend[$];
  logic [7:0] rmem [2][16];
  logic       s_ready [2], s_rv [2];
  logic [7:0] s_rd [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    localparam int LATK = (k == 0) ? 2 : 1;
    logic [7:0] bmem [16] = '{default: '0};
    logic [7:0] r1, dout;

    // Write-first BRAM model with optional output register.
    always @(posedge clk) begin
      if (bram_en[k]) begin
        if (bram_we[k]) bmem[bram_addr[k]] <= bram_di[k];
        if (LATK == 2) r1   <= bram_we[k] ? bram_di[k] : bmem[bram_addr[k]];
        else           dout <= bram_we[k] ? bram_di[k] : bmem[bram_addr[k]];
      end
      if (LATK == 2) dout <= r1;
    end

    bram_read_server #(
      .ADDR_WIDTH(4), .DATA_WIDTH(8), .PIPELINED((k == 0) ? 1 : 0), .RESP_DEPTH(DEPTH)
    ) u_dut (
      .CLK(clk), .RST(rst),
      .REQ_VALID(req_valid[k]), .REQ_READY(req_ready[k]), .REQ_WRITE(req_write[k]),
      .REQ_ADDR(req_addr[k]), .REQ_DATA(req_data[k]),
      .RSP_VALID(rsp_valid[k]), .RSP_READY(rsp_ready[k]), .RSP_DATA(rsp_data[k]),
      .BRAM_EN(bram_en[k]), .BRAM_WE(bram_we[k]), .BRAM_ADDR(bram_addr[k]),
      .BRAM_DI(bram_di[k]), .BRAM_DO(dout)
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Compare one instance against the model for the current cycle, then
  // advance the model across the coming clock edge.
  task automatic model_step(input int k);
    int   h = -1;
    int   n = 0;
    int   lat = (k == 0) ? 2 : 1;
    logic er, ev;
    foreach (pend[i]) if (pend[i].k == k) begin
      if (h < 0) h = i;
      n++;
    end
    // Outstanding reads (in flight or queued) each hold one of DEPTH slots.
    er = !rst && (n < DEPTH);
    ev = !rst && (h >= 0) && (pend[h].rdy <= cyc);
    s_ready[k] = req_ready[k];
    s_rv[k]    = rsp_valid[k];
    s_rd[k]    = rsp_data[k];
    chk($sformatf("req_ready%0d", k), req_ready[k], er);
    chk($sformatf("rsp_valid%0d", k), rsp_valid[k], ev);
    if (ev) chk($sformatf("rsp_data%0d", k), rsp_data[k], pend[h].d);
    chk($sformatf("bram_en%0d", k), bram_en[k], req_valid[k] & er);
    chk($sformatf("bram_we%0d", k), bram_we[k], req_valid[k] & er & req_write[k]);
    if (req_valid[k] && er) begin
      chk($sformatf("bram_addr%0d", k), bram_addr[k], req_addr[k]);
      chk($sformatf("bram_di%0d", k), bram_di[k], req_data[k]);
    end
    if (rst) begin
      for (int i = pend.size() - 1; i >= 0; i--) if (pend[i].k == k) pend.delete(i);
    end else begin
      if (ev && rsp_ready[k]) pend.delete(h);
      if (req_valid[k] && er) begin
        if (req_write[k]) rmem[k][req_addr[k]] = req_data[k];
        else pend.push_back('{k, rmem[k][req_addr[k]], cyc + lat + 1});
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) model_step(k);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_write[k] = 1'b0; req_addr[k] = '0;
      req_data[k] = '0; rsp_ready[k] = 1'b1;
    end
  endtask

  task automatic do_req(input int k, input logic wr, input int a, input int d);
    req_valid[k] = 1'b1; req_write[k] = wr;
    req_addr[k] = 4'(a); req_data[k] = 8'(d);
    tick();
    req_valid[k] = 1'b0; req_write[k] = 1'b0;
  endtask

  initial begin
    int nacc, ngot, c0;
    errors = 0; checks = 0; cyc = 0;
    for (int k = 0; k < 2; k++) for (int a = 0; a < 16; a++) rmem[k][a] = '0;
    idle_all();
    rst = 1'b1;
    @(posedge clk); #1;

    // Reset state.
    tick();
    chk("rst_ready0", s_ready[0], 0); chk("rst_rv0", s_rv[0], 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_ready0", s_ready[0], 1); chk("post_rst_ready1", s_ready[1], 1);

    // Write 0xA5 @3 then read @3 on the pipelined instance.
    rsp_ready[0] = 1'b0;
    do_req(0, 1'b1, 3, 8'hA5);
    do_req(0, 1'b0, 3, 0);
    chk("t1_rd_accept", s_ready[0], 1);
    tick(); tick();
    chk("t1_not_yet", s_rv[0], 0);
    tick();
    chk("t1_valid", s_rv[0], 1); chk("t1_data", s_rd[0], 8'hA5);
    tick();
    chk("t1_hold_valid", s_rv[0], 1); chk("t1_hold_data", s_rd[0], 8'hA5);
    rsp_ready[0] = 1'b1;
    tick();
    tick();
    chk("t1_popped", s_rv[0], 0);

    // Non-pipelined back-to-back reads of mem[i]=i.
    for (int i = 0; i < 8; i++) do_req(1, 1'b1, i, i);
    c0 = cyc; ngot = 0;
    for (int j = 0; j < 12; j++) begin
      req_valid[1] = (j < 8); req_write[1] = 1'b0; req_addr[1] = 4'(j);
      tick();
      if (j < 8) chk("t2_ready", s_ready[1], 1);
      if (s_rv[1]) begin
        chk("t2_data", s_rd[1], ngot);
        chk("t2_cycle", cyc - 1, c0 + 2 + ngot);
        ngot++;
      end
    end
    req_valid[1] = 1'b0;
    chk("t2_count", ngot, 8);

    // Backpressure: six reads against four credits.
    for (int i = 0; i < 6; i++) do_req(0, 1'b1, 8 + i, 8'h10 + i);
    rsp_ready[0] = 1'b0; nacc = 0;
    for (int j = 0; j < 8; j++) begin
      req_valid[0] = 1'b1; req_addr[0] = 4'(8 + nacc);
      tick();
      if (s_ready[0]) nacc++;
    end
    chk("t3_accepted", nacc, 4);
    chk("t3_ready_low", s_ready[0], 0);
    rsp_ready[0] = 1'b1; ngot = 0;
    for (int j = 0; j < 40 && ngot < 6; j++) begin
      req_valid[0] = (nacc < 6); req_addr[0] = 4'(8 + nacc);
      tick();
      if (s_ready[0] && req_valid[0]) nacc++;
      if (s_rv[0]) begin
        chk("t3_data", s_rd[0], 8'h10 + ngot);
        ngot++;
      end
    end
    req_valid[0] = 1'b0;
    chk("t3_total_acc", nacc, 6);
    chk("t3_total_rsp", ngot, 6);

    // Same-cycle pop and read accept with one credit left.
    rsp_ready[0] = 1'b0;
    for (int i = 0; i < 3; i++) do_req(0, 1'b0, i, 0);
    tick(); tick(); tick();
    rsp_ready[0] = 1'b1;
    do_req(0, 1'b0, 3, 0);
    chk("t4_ready_at_swap", s_ready[0], 1); chk("t4_valid_at_swap", s_rv[0], 1);
    rsp_ready[0] = 1'b0;
    tick();
    chk("t4_ready_after", s_ready[0], 1);
    rsp_ready[0] = 1'b1;
    for (int j = 0; j < 8; j++) tick();

    // Reset with one queued response and two reads in flight.
    rsp_ready[0] = 1'b0;
    do_req(0, 1'b0, 5, 0);
    tick();
    do_req(0, 1'b0, 6, 0);
    do_req(0, 1'b0, 7, 0);
    chk("t5_queued", s_rv[0], 1);
    rst = 1'b1;
    tick();
    chk("t5_rst_ready", s_ready[0], 0); chk("t5_rst_rv", s_rv[0], 0);
    rst = 1'b0;
    tick();
    chk("t5_after_rv", s_rv[0], 0); chk("t5_after_ready", s_ready[0], 1);
    rsp_ready[0] = 1'b1;
    for (int j = 0; j < 6; j++) begin
      tick();
      chk("t5_no_stale", s_rv[0], 0);
    end

    // Random traffic on both instances.
    for (int n = 0; n < 5000; n++) begin
      for (int k = 0; k < 2; k++) begin
        req_valid[k] = ($urandom_range(0, 9) < 7);
        req_write[k] = ($urandom_range(0, 9) < 3);
        req_addr[k]  = 4'($urandom_range(0, 15));
        req_data[k]  = 8'($urandom);
        rsp_ready[k] = ($urandom_range(0, 9) < 6);
      end
      tick();
    end
    idle_all();
    for (int j = 0; j < 10; j++) tick();
    chk("drained", pend.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
